// File: rtl/rx_port_sched.sv
// rtl/rx_port_sched.sv - ingress scheduler for the 4-port MAC decoder
// Purpose: picks which PHY RX FIFO the decoder serves next and holds the grant
//   until frame_done or a watchdog release. Tiers: afull > half > frame_exist,
//   with one round-robin pointer shared by all tiers.
// Optional feature macro: STARVE_GUARD_EN (starvation promotion to tier 3).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   port_en[3:0]      static per-port enable mask
//   frame_exist[3:0]  FIFO holds a complete frame
//   half[3:0]         FIFO half-full
//   afull[3:0]        FIFO almost-full
//   sched_req         decoder idle and able to accept a frame
//   frame_done        1-cycle pulse, granted frame finished
//   gnt_valid         grant open, gnt_id/gnt_tier valid
//   gnt_id[1:0]       granted port
//   gnt_tier[1:0]     0=exist 1=half 2=afull 3=starved-promoted
//   busy              same as gnt_valid
//   timeout_err       1-cycle pulse on watchdog release
//   starve_flag[3:0]  per-port starvation counter at limit (0 without the macro)
module rx_port_sched #(
   parameter int TIMEOUT_CYC  = 4096,
   parameter int TIMEOUT_W    = 13,
   parameter int STARVE_LIMIT = 8,
   parameter int STARVE_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] port_en,
   input  logic [3:0] frame_exist,
   input  logic [3:0] half,
   input  logic [3:0] afull,
   input  logic       sched_req,
   input  logic       frame_done,
   output logic       gnt_valid,
   output logic [1:0] gnt_id,
   output logic [1:0] gnt_tier,
   output logic       busy,
   output logic       timeout_err,
   output logic [3:0] starve_flag
);

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << TIMEOUT_W) ||
       STARVE_LIMIT < 1 || STARVE_LIMIT >= (1 << STARVE_W)) begin : g_cfg_check
      $error("rx_port_sched: parameter widths cannot hold the configured limits");
   end

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t               state_q, state_d;
   logic                 gnt_valid_q, gnt_valid_d;
   logic [1:0]           gnt_id_q, gnt_id_d;
   logic [1:0]           gnt_tier_q, gnt_tier_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [1:0]           rr_last_q, rr_last_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

   logic [3:0] elig;
   logic [3:0] starved;
   logic [3:0] m3, m2, m1, m0;
   logic [3:0] sel_mask;
   logic [1:0] sel_tier;
   logic [1:0] win;
   logic [1:0] idx;
   logic       found;
   logic       grant_evt;
   logic       expire;

   // Eligibility ignores frame_exist when afull/half are set: a filling FIFO
   // must be drained even before a complete frame is flagged.
   assign elig   = port_en & (afull | half | frame_exist);
   assign expire = (wdog_q == TIMEOUT_W'(TIMEOUT_CYC - 1));

`ifdef STARVE_GUARD_EN
   logic [STARVE_W-1:0] starve_cnt_q [4];
   logic [STARVE_W-1:0] starve_cnt_d [4];

   always_comb begin
      for (int p = 0; p < 4; p++) begin
         starved[p] = (starve_cnt_q[p] == STARVE_W'(STARVE_LIMIT));
      end
   end

   // Counters move only on grant events; a port drops out of the race
   // (ineligible or disabled) and loses its accumulated credit.
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         starve_cnt_d[p] = starve_cnt_q[p];
         if (grant_evt) begin
            if (win == 2'(p) || !elig[p]) begin
               starve_cnt_d[p] = '0;
            end else if (starve_cnt_q[p] < STARVE_W'(STARVE_LIMIT)) begin
               starve_cnt_d[p] = starve_cnt_q[p] + STARVE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 4; p++) begin
         if (rst) begin
            starve_cnt_q[p] <= '0;
         end else begin
            starve_cnt_q[p] <= starve_cnt_d[p];
         end
      end
   end

   assign starve_flag = starved;
`else
   assign starved     = '0;
   assign starve_flag = '0;
`endif

   // Tier membership is exclusive: each eligible port lands in exactly one mask.
   assign m3 = elig & starved;
   assign m2 = elig & ~starved & afull;
   assign m1 = elig & ~starved & ~afull & half;
   assign m0 = elig & ~starved & ~afull & ~half & frame_exist;

   always_comb begin
      sel_mask = m0;
      sel_tier = 2'd0;
      if (|m3) begin
         sel_mask = m3;
         sel_tier = 2'd3;
      end else if (|m2) begin
         sel_mask = m2;
         sel_tier = 2'd2;
      end else if (|m1) begin
         sel_mask = m1;
         sel_tier = 2'd1;
      end
   end

   // Round-robin search starting just after the last winner; rr_last itself
   // is tried last, so a lone requester can still win back to back.
   always_comb begin
      found = 1'b0;
      win   = rr_last_q;
      idx   = rr_last_q;
      for (int i = 1; i <= 4; i++) begin
         idx = rr_last_q + 2'(i);
         if (!found && sel_mask[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         gnt_valid_q   <= 1'b0;
         gnt_id_q      <= 2'd0;
         gnt_tier_q    <= 2'd0;
         timeout_err_q <= 1'b0;
         rr_last_q     <= 2'd3;
         wdog_q        <= '0;
      end else begin
         state_q       <= state_d;
         gnt_valid_q   <= gnt_valid_d;
         gnt_id_q      <= gnt_id_d;
         gnt_tier_q    <= gnt_tier_d;
         timeout_err_q <= timeout_err_d;
         rr_last_q     <= rr_last_d;
         wdog_q        <= wdog_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (sched_req && |elig) state_d = S_BUSY;
         S_BUSY: if (frame_done || expire) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic; frame_done wins over a coincident expiry.
   always_comb begin
      grant_evt     = 1'b0;
      gnt_valid_d   = gnt_valid_q;
      gnt_id_d      = gnt_id_q;
      gnt_tier_d    = gnt_tier_q;
      timeout_err_d = 1'b0;
      rr_last_d     = rr_last_q;
      wdog_d        = wdog_q;
      case (state_q)
         S_IDLE: begin
            if (sched_req && |elig) begin
               grant_evt   = 1'b1;
               gnt_valid_d = 1'b1;
               gnt_id_d    = win;
               gnt_tier_d  = sel_tier;
               rr_last_d   = win;
               wdog_d      = '0;
            end
         end
         S_BUSY: begin
            if (frame_done) begin
               gnt_valid_d = 1'b0;
            end else if (expire) begin
               gnt_valid_d   = 1'b0;
               timeout_err_d = 1'b1;
            end else begin
               wdog_d = wdog_q + TIMEOUT_W'(1);
            end
         end
         default: gnt_valid_d = 1'b0;
      endcase
   end

   assign gnt_valid   = gnt_valid_q;
   assign gnt_id      = gnt_id_q;
   assign gnt_tier    = gnt_tier_q;
   assign busy        = gnt_valid_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rx_port_sched.sv
// tb/tb_rx_port_sched.sv - self-checking bench for rx_port_sched
// Purpose: directed scenarios plus randomized traffic, every cycle compared
//   against a behavioural model of the scheduling rules.
// Ports: none (top-level bench); drives every rx_port_sched port.
// Optional feature macro: STARVE_GUARD_EN (enables the starvation scenario).
module tb_rx_port_sched;

   localparam int TO    = 20;
   localparam int TO_W  = 5;
   localparam int SLIM  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] port_en, frame_exist, half, afull;
   logic       sched_req, frame_done;
   logic       gnt_valid, busy, timeout_err;
   logic [1:0] gnt_id, gnt_tier;
   logic [3:0] starve_flag;

   int compared = 0;
   int mismatched = 0;

   // behavioural model state
   bit m_valid;
   int m_id, m_tier, m_rr, m_age;
   bit m_to;
   int m_cnt [4];

   always #5 clk = ~clk;

   rx_port_sched #(.TIMEOUT_CYC(TO), .TIMEOUT_W(TO_W), .STARVE_LIMIT(SLIM), .STARVE_W(4)) dut (
      .clk(clk), .rst(rst), .port_en(port_en), .frame_exist(frame_exist),
      .half(half), .afull(afull), .sched_req(sched_req), .frame_done(frame_done),
      .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_tier(gnt_tier), .busy(busy),
      .timeout_err(timeout_err), .starve_flag(starve_flag));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Tier of port p from the current inputs, -1 when not eligible.
   function automatic int ptier(int p);
      int t;
      if (!port_en[p]) return -1;
      if (afull[p]) t = 2;
      else if (half[p]) t = 1;
      else if (frame_exist[p]) t = 0;
      else return -1;
`ifdef STARVE_GUARD_EN
      if (m_cnt[p] == SLIM) t = 3;
`endif
      return t;
   endfunction

   function automatic int mflags();
      int f = 0;
`ifdef STARVE_GUARD_EN
      for (int p = 0; p < 4; p++) if (m_cnt[p] == SLIM) f |= (1 << p);
`endif
      return f;
   endfunction

   // Advance the model by one clock using the inputs as they stand, then let
   // the DUT take the same edge and compare every output.
   task automatic tick();
      int best, w, tiers [4];
      m_to = 0;
      if (rst) begin
         m_valid = 0; m_id = 0; m_tier = 0; m_rr = 3; m_age = 0;
         for (int p = 0; p < 4; p++) m_cnt[p] = 0;
      end else if (!m_valid) begin
         best = -1;
         for (int p = 0; p < 4; p++) begin
            tiers[p] = ptier(p);
            if (tiers[p] > best) best = tiers[p];
         end
         if (sched_req && best >= 0) begin
            w = -1;
            for (int k = 1; k <= 4; k++)
               if (w < 0 && tiers[(m_rr + k) % 4] == best) w = (m_rr + k) % 4;
            for (int p = 0; p < 4; p++) begin
               if (p == w || tiers[p] < 0) m_cnt[p] = 0;
               else if (m_cnt[p] < SLIM) m_cnt[p]++;
            end
            m_valid = 1; m_id = w; m_tier = best; m_rr = w; m_age = 1;
         end
      end else begin
         if (frame_done) m_valid = 0;
         else if (m_age == TO) begin m_valid = 0; m_to = 1; end
         else m_age++;
      end
      @(posedge clk);
      #1;
      chk("gnt_valid", gnt_valid, m_valid);
      chk("busy", busy, m_valid);
      chk("timeout_err", timeout_err, m_to);
      chk("starve_flag", starve_flag, mflags());
      if (m_valid) begin
         chk("gnt_id", gnt_id, m_id);
         chk("gnt_tier", gnt_tier, m_tier);
      end
   endtask

   task automatic do_reset();
      rst = 1; sched_req = 0; frame_done = 0;
      tick();
      rst = 0;
   endtask

   task automatic grant();
      sched_req = 1; tick(); sched_req = 0;
   endtask

   task automatic close();
      frame_done = 1; tick(); frame_done = 0;
   endtask

   int n, p0_hits;

   initial begin
      rst = 1; port_en = 4'hF; frame_exist = 0; half = 0; afull = 0;
      sched_req = 0; frame_done = 0;
      m_rr = 3;
      @(negedge clk);
      do_reset();
      chk("rst_gnt_valid", gnt_valid, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_gnt_tier", gnt_tier, 0);

      // 1) single port with a frame
      frame_exist = 4'b0100;
      grant();
      chk("t1_valid", gnt_valid, 1);
      chk("t1_id", gnt_id, 2);
      chk("t1_tier", gnt_tier, 0);
      close();
      chk("t1_closed", gnt_valid, 0);
      close();  // frame_done while idle is ignored
      chk("t1_idle_done", gnt_valid, 0);

      // 2) round robin across all four
      do_reset();
      frame_exist = 4'hF;
      for (int k = 0; k < 5; k++) begin
         grant();
         chk("t2_id", gnt_id, k % 4);
         close();
      end

      // 3) tier priority
      do_reset();
      frame_exist = 4'hF; half = 4'b0100; afull = 4'b1000;
      grant();
      chk("t3_id_afull", gnt_id, 3);
      chk("t3_tier_afull", gnt_tier, 2);
      close();
      afull = 0;
      grant();
      chk("t3_id_half", gnt_id, 2);
      chk("t3_tier_half", gnt_tier, 1);
      // inputs and sched_req are ignored while busy
      half = 0; port_en = 4'b1011; sched_req = 1;
      tick(); tick();
      sched_req = 0;
      chk("t3_frozen_id", gnt_id, 2);
      close();
      port_en = 4'hF;

      // 4) watchdog release
      do_reset();
      frame_exist = 4'b0010;
      grant();
      n = 0;
      for (int c = 0; c < TO + 3; c++) begin
         tick();
         if (timeout_err) n++;
      end
      chk("t4_valid_fell", gnt_valid, 0);
      chk("t4_timeout_once", n, 1);
      grant();
      chk("t4_regrant", gnt_id, 1);
      // frame_done coinciding with expiry is a normal close
      for (int c = 0; c < TO - 1; c++) tick();
      close();
      chk("t4_done_at_expiry", timeout_err, 0);

      // 5) reset while busy, then a disabled port
      do_reset();
      frame_exist = 4'hF;
      grant(); grant(); tick();
      chk("t5_busy_before_rst", gnt_valid, 1);
      do_reset();
      chk("t5_rst_drop", gnt_valid, 0);
      grant();
      chk("t5_first_p0", gnt_id, 0);
      close();
      port_en = 4'b1110;
      p0_hits = 0;
      for (int k = 0; k < 8; k++) begin
         grant();
         if (gnt_id == 2'd0) p0_hits++;
         close();
      end
      chk("t5_p0_never", p0_hits, 0);
      port_en = 4'hF;

`ifdef STARVE_GUARD_EN
      // 6) starvation promotion
      do_reset();
      frame_exist = 4'b0001; half = 0; afull = 4'b0010;
      for (int k = 0; k < SLIM; k++) begin
         grant();
         chk("t6_p1", gnt_id, 1);
         close();
      end
      chk("t6_flag", starve_flag[0], 1);
      grant();
      chk("t6_promoted_id", gnt_id, 0);
      chk("t6_promoted_tier", gnt_tier, 3);
      chk("t6_flag_clear", starve_flag[0], 0);
      close();
`endif

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 31) == 0) port_en = 4'($urandom);
         if ($urandom_range(0, 3) == 0) frame_exist = 4'($urandom);
         if ($urandom_range(0, 3) == 0) half = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 3) == 0) afull = 4'($urandom) & 4'($urandom) & 4'($urandom);
         sched_req  = ($urandom_range(0, 1) == 0);
         frame_done = ($urandom_range(0, 7) == 0);
         rst        = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 0; sched_req = 0; frame_done = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
